lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
- Downstream consumer of the 8-bit LFSR pattern generator; samples its `out` bus and checks the stream against a local predictor.
- Self-synchronises from the incoming data, declares lock, and counts word errors for link/BIST status.
- Sits between the LFSR (or the channel it drives) and the status/CSR logic.

Parameters:
- WIDTH, 8, data width; must match the generator.
- TAPS, 8'hB8, feedback tap mask.
- LOCK_CNT, 4, consecutive correct predictions needed to declare lock (≥1).
- LOSS_CNT, 3, consecutive mismatches in LOCKED that drop lock (≥1).
- ERR_W, 16, error counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset; all state clears immediately while low.
- in_valid  input  1  in_data is a new LFSR word this cycle; tie high when the LFSR advances every clock.
- in_data  input  WIDTH  received LFSR word.
- clr  input  1  synchronous clear of err_cnt and word_cnt; does not affect lock state.
- locked  output  1  checker is in LOCKED.
- err_pulse  output  1  one-cycle pulse per mismatching word while LOCKED.
- err_cnt  output  ERR_W  saturating count of mismatched words while LOCKED.
- word_cnt  output  32  saturating count of words checked while LOCKED.

Behaviour:
- Next-state function: nxt(x) = {x[WIDTH-2:0], ^(x & TAPS)}.
  - With the default TAPS, the sequence from 01 is 01→02→04→08→11→…
- Reset (rst low) values:
  - state=SEED, pred=0, match_cnt=0, miss_cnt=0.
  - locked=0, err_pulse=0, err_cnt=0, word_cnt=0.
- Cycles with in_valid=0 change nothing; err_pulse is driven 0 on those cycles.
- All outputs are registered.
- SEED:
  - On valid with in_data≠0: pred<=nxt(in_data), match_cnt<=0, go to VERIFY.
  - in_data==0 is the LFSR lock-up value: it is rejected and the state stays SEED.
- VERIFY:
  - On valid with in_data==pred: pred<=nxt(in_data), match_cnt++. When match_cnt reaches LOCK_CNT-1 on a match, go to LOCKED; locked rises the cycle after the LOCK_CNT-th matching word.
  - On valid with a mismatch: go to SEED with no error counted. That word is not reused as a seed; the next valid word reseeds.
- LOCKED:
  - pred<=nxt(pred) on each valid word. The predictor free-runs and is never reloaded from data, so a corrupted word does not propagate errors.
  - word_cnt++ on each valid word, saturating at all-ones.
  - Mismatch: err_pulse=1 next cycle, err_cnt++ (saturates at 2^ERR_W-1, no wrap), miss_cnt++.
  - When miss_cnt reaches LOSS_CNT: go to SEED, locked=0 the next cycle. The LOSS_CNT-th mismatch is still counted in err_cnt.
  - Match: miss_cnt<=0.
- clr:
  - clr has priority over increment in the same cycle: counters become 0, and that cycle's error is not counted.
  - err_pulse is still generated when clr coincides with a mismatch.
- Reset mid-operation returns to SEED immediately; no residual pulses after rst deasserts.
- Latency from input word to err_pulse/counter update: 1 clock.

Test Plan:
- Reset, then a clean stream from seed 01 (01,02,04,08,11,…) with in_valid=1 → locked=1 in the cycle after the 5th word (seed + 4 matches); err_cnt=0; word_cnt increments by 1 per cycle thereafter.
- Locked, flip bit 0 of one word (e.g. 11→10) → exactly one err_pulse one cycle later; err_cnt=1; locked stays 1; subsequent words match with no further errors.
- Locked, force in_data=00 for 3 consecutive words → err_cnt=3, locked falls the cycle after the 3rd bad word; on resumption the checker reseeds and relocks after 5 valid words.
- Stream of 00 words after reset → stays in SEED, locked=0, err_cnt=0 indefinitely.
- With ERR_W=4, inject 20 isolated single-word errors while locked (never 3 consecutive) → err_cnt saturates at 15 and holds; assert clr for 1 cycle → err_cnt=0 and word_cnt=0, locked unchanged.
- Drop rst low asynchronously mid-LOCKED (off a clock edge) → locked, err_cnt and word_cnt go to 0 without waiting for clk; after release, relock occurs as in the first scenario. Also toggle in_valid 1/0 while locked → state and counters freeze on invalid cycles.

Source files
------------

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for an LFSR word stream: seeds a local predictor
// from the data, declares lock after a run of correct predictions, and counts word errors.
module lfsr_checker #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] TAPS     = 8'hB8,
  parameter int               LOCK_CNT = 4,
  parameter int               LOSS_CNT = 3,
  parameter int               ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [31:0]      word_cnt
);

  localparam int MC_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam int MS_W = $clog2(LOSS_CNT + 1);

  // SEED   | waiting for a non-zero word to load the predictor
  // VERIFY | predictor seeded, counting consecutive correct predictions
  // LOCKED | predictor free-runs; mismatches are counted as word errors
  typedef enum logic [1:0] {
    SEED,
    VERIFY,
    LOCKED
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] pred, pred_nx;
  logic [MC_W-1:0]  match_cnt, match_nx;
  logic [MS_W-1:0]  miss_cnt, miss_nx;
  logic             hit;
  logic             miss_word;
  logic             count_word;

  function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], ^(x & TAPS)};
  endfunction

  assign hit = (in_data == pred);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SEED;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    pred_nx    = pred;
    match_nx   = match_cnt;
    miss_nx    = miss_cnt;
    miss_word  = 1'b0;
    count_word = 1'b0;
    if (in_valid) begin
      case (state)
        SEED: begin
          // all-zero is the LFSR lock-up value and can never seed a valid stream
          if (in_data != '0) begin
            pred_nx  = nxt(in_data);
            match_nx = '0;
            state_nx = VERIFY;
          end
        end
        VERIFY: begin
          if (hit) begin
            pred_nx = nxt(in_data);
            if (match_cnt == MC_W'(LOCK_CNT - 1)) begin
              state_nx = LOCKED;
              miss_nx  = '0;
            end else begin
              match_nx = match_cnt + 1'b1;
            end
          end else begin
            state_nx = SEED;
          end
        end
        LOCKED: begin
          // never reload from data so a single bad word costs exactly one error
          pred_nx    = nxt(pred);
          count_word = 1'b1;
          if (hit) begin
            miss_nx = '0;
          end else begin
            miss_word = 1'b1;
            if (miss_cnt == MS_W'(LOSS_CNT - 1)) begin
              state_nx = SEED;
              miss_nx  = '0;
            end else begin
              miss_nx = miss_cnt + 1'b1;
            end
          end
        end
        default: state_nx = SEED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      word_cnt  <= '0;
    end else begin
      pred      <= pred_nx;
      match_cnt <= match_nx;
      miss_cnt  <= miss_nx;
      locked    <= (state_nx == LOCKED);
      err_pulse <= miss_word;
      if (clr) begin
        err_cnt  <= '0;
        word_cnt <= '0;
      end else begin
        if (miss_word && !(&err_cnt))   err_cnt  <= err_cnt + 1'b1;
        if (count_word && !(&word_cnt)) word_cnt <= word_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker (ERR_W=4 so error saturation is reachable).
module tb_lfsr_checker;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        clr;
  logic        locked;
  logic        err_pulse;
  logic [3:0]  err_cnt;
  logic [31:0] word_cnt;

  int n_checks;
  int n_errors;
  logic [7:0] x;

  // hand-computed stream from seed 01 with taps B8
  logic [7:0] seq [0:7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
  // relock vector with a corrupted word (04 -> 99) right after seeding
  logic [7:0] reseed [0:7] = '{8'h01, 8'h02, 8'h99, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};

  lfsr_checker #(.ERR_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clr       (clr),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .word_cnt  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] nxt8(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_good();
    send(1'b1, x);
    x = nxt8(x);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b0;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #12;
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_pulse", 32'(err_pulse), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    check("rst_words", word_cnt, 32'd0);
    rst = 1'b1;

    // clean stream from 01: lock after the fifth word
    for (int i = 0; i < 5; i++) begin
      send(1'b1, seq[i]);
      if (i == 3) check("lock_early", 32'(locked), 32'd0);
    end
    check("lock_5th", 32'(locked), 32'd1);
    check("lock_words", word_cnt, 32'd0);
    x = seq[5];
    for (int i = 0; i < 3; i++) send_good();
    check("clean_words", word_cnt, 32'd3);
    check("clean_err", 32'(err_cnt), 32'd0);
    check("clean_pulse", 32'(err_pulse), 32'd0);

    // single bit-0 flip
    send(1'b1, x ^ 8'h01);
    x = nxt8(x);
    check("flip_pulse", 32'(err_pulse), 32'd1);
    check("flip_err", 32'(err_cnt), 32'd1);
    check("flip_locked", 32'(locked), 32'd1);
    check("flip_words", word_cnt, 32'd4);
    send_good();
    check("flip_pulse_off", 32'(err_pulse), 32'd0);
    check("flip_err_hold", 32'(err_cnt), 32'd1);
    for (int i = 0; i < 3; i++) send_good();
    check("flip_after_err", 32'(err_cnt), 32'd1);
    check("flip_after_words", word_cnt, 32'd8);

    // invalid cycles freeze everything, even with garbage data
    send(1'b0, 8'hFF);
    send(1'b0, x ^ 8'h55);
    check("inv_words", word_cnt, 32'd8);
    check("inv_err", 32'(err_cnt), 32'd1);
    check("inv_pulse", 32'(err_pulse), 32'd0);
    check("inv_locked", 32'(locked), 32'd1);
    send_good();
    check("inv_resume_words", word_cnt, 32'd9);
    check("inv_resume_err", 32'(err_cnt), 32'd1);

    // clr wins over the increment of a valid word
    clr = 1'b1;
    send_good();
    clr = 1'b0;
    check("clr_err", 32'(err_cnt), 32'd0);
    check("clr_words", word_cnt, 32'd0);
    check("clr_locked", 32'(locked), 32'd1);

    // three zero words drop lock; the third is still counted
    send(1'b1, 8'h00); x = nxt8(x);
    check("loss1_err", 32'(err_cnt), 32'd1);
    check("loss1_locked", 32'(locked), 32'd1);
    send(1'b1, 8'h00); x = nxt8(x);
    check("loss2_locked", 32'(locked), 32'd1);
    send(1'b1, 8'h00); x = nxt8(x);
    check("loss3_err", 32'(err_cnt), 32'd3);
    check("loss3_locked", 32'(locked), 32'd0);
    check("loss3_words", word_cnt, 32'd3);
    for (int i = 0; i < 4; i++) send_good();
    check("relock_early", 32'(locked), 32'd0);
    send_good();
    check("relock", 32'(locked), 32'd1);
    check("relock_err", 32'(err_cnt), 32'd3);
    check("relock_words", word_cnt, 32'd3);

    // saturation with 20 isolated errors
    clr = 1'b1;
    send_good();
    clr = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      send(1'b1, x ^ 8'h01);
      x = nxt8(x);
      if (i == 15) check("sat_15", 32'(err_cnt), 32'd15);
      if (i == 16) check("sat_hold", 32'(err_cnt), 32'd15);
      if (i == 20) check("sat_pulse", 32'(err_pulse), 32'd1);
      send_good();
    end
    check("sat_err", 32'(err_cnt), 32'd15);
    check("sat_locked", 32'(locked), 32'd1);
    check("sat_words", word_cnt, 32'd40);

    // two consecutive misses then a match keep lock
    send(1'b1, x ^ 8'h80); x = nxt8(x);
    send(1'b1, x ^ 8'h80); x = nxt8(x);
    send_good();
    check("two_miss_locked", 32'(locked), 32'd1);

    // clr coinciding with a mismatch: pulse still fires, nothing counted
    clr = 1'b1;
    send(1'b1, x ^ 8'h01);
    x = nxt8(x);
    clr = 1'b0;
    check("clrmiss_pulse", 32'(err_pulse), 32'd1);
    check("clrmiss_err", 32'(err_cnt), 32'd0);
    check("clrmiss_words", word_cnt, 32'd0);
    check("clrmiss_locked", 32'(locked), 32'd1);

    // asynchronous reset mid-LOCKED
    send(1'b1, x ^ 8'h01); x = nxt8(x);
    send_good();
    #3;
    rst = 1'b0;
    #1;
    check("arst_locked", 32'(locked), 32'd0);
    check("arst_err", 32'(err_cnt), 32'd0);
    check("arst_words", word_cnt, 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_good();
      if (i == 0) check("arst_no_pulse", 32'(err_pulse), 32'd0);
    end
    check("arst_relock_early", 32'(locked), 32'd0);
    send_good();
    check("arst_relock", 32'(locked), 32'd1);

    // zero stream never seeds
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    for (int i = 0; i < 10; i++) send(1'b1, 8'h00);
    check("zero_locked", 32'(locked), 32'd0);
    check("zero_err", 32'(err_cnt), 32'd0);
    check("zero_words", word_cnt, 32'd0);

    // mismatch in VERIFY reseeds from the following word, not the bad one
    for (int i = 0; i < 7; i++) send(1'b1, reseed[i]);
    check("verify_miss_early", 32'(locked), 32'd0);
    send(1'b1, reseed[7]);
    check("verify_miss_lock", 32'(locked), 32'd1);
    check("verify_miss_err", 32'(err_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
